// File: rtl/fp_accel_pkg.sv
// rtl/fp_accel_pkg.sv - shared types and sizing helpers for the fingerprint accelerator
package fp_accel_pkg;

    // Threshold loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_t;

    // Width needed for counts 0..vector_width inclusive (C may equal VECTOR_WIDTH)
    function automatic int cnt_width(input int vector_width);
        return $clog2(vector_width + 1);
    endfunction

    // Largest entry value a cw-bit table word can hold
    function automatic int sat_value(input int cw);
        return (1 << cw) - 1;
    endfunction

    localparam int DEFAULT_VECTOR_WIDTH = 920;
    localparam int DEFAULT_CNT_WIDTH    = cnt_width(DEFAULT_VECTOR_WIDTH);
    localparam int ENTRY_SAT            = sat_value(DEFAULT_CNT_WIDTH);

endpackage

// File: rtl/threshold_entry_gen.sv
// rtl/threshold_entry_gen.sv - ratio accumulator with ceil and saturate to a table entry
module threshold_entry_gen
    import fp_accel_pkg::*;
#(
    parameter int CNT_WIDTH   = 10,
    parameter int FRAC_BITS   = 8,
    parameter int RATIO_WIDTH = CNT_WIDTH + FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   en,
    input  logic [RATIO_WIDTH-1:0] ratio,
    output logic [CNT_WIDTH-1:0]   next_entry
);

    // Wide enough that VECTOR_WIDTH * max ratio never wraps
    localparam int ACC_W   = CNT_WIDTH + RATIO_WIDTH;
    localparam int RND_W   = ACC_W + 1;
    localparam int SAT_INT = sat_value(CNT_WIDTH);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [RND_W-1:0] rounded;
    logic [RND_W-1:0] ceil_val;

    // Next accumulator value and its entry; the caller registers next_entry,
    // so the entry lines up with the address written in the same cycle
    always_comb begin
        acc_next = acc;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc + ACC_W'(ratio);
        end
        rounded    = {1'b0, acc_next} + RND_W'((1 << FRAC_BITS) - 1);
        ceil_val   = rounded >> FRAC_BITS;
        next_entry = (ceil_val > RND_W'(SAT_INT)) ? CNT_WIDTH'(SAT_INT)
                                                  : ceil_val[CNT_WIDTH-1:0];
    end

    // Accumulator holds c * ratio for the next address to be written
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/threshold_table_loader.sv
// rtl/threshold_table_loader.sv - sequences drain and rewrite of the comparator threshold RAM
module threshold_table_loader
    import fp_accel_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
    parameter int FRAC_BITS    = 8,
    parameter int RATIO_WIDTH  = CNT_WIDTH + FRAC_BITS,
    parameter int PIPE_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_Start,
    input  logic [RATIO_WIDTH-1:0] i_Ratio,
    output logic                   o_StartAck,
    output logic                   o_Loaded,
    output logic                   o_InReady,
    output logic [CNT_WIDTH-1:0]   o_BRAM_Addr,
    output logic [CNT_WIDTH-1:0]   o_BRAM_Din,
    output logic                   o_BRAM_En,
    output logic                   o_BRAM_WrEn
);

    localparam int                   DRAIN_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);

    loader_state_t            state;
    logic [RATIO_WIDTH-1:0]   r_Ratio;
    logic [DRAIN_W-1:0]       drain_cnt;
    logic                     accept;
    logic                     gen_en;
    logic [CNT_WIDTH-1:0]     next_entry;

    // Start is honoured only when no rewrite is in progress; the accumulator
    // clears on acceptance and steps once per LOAD cycle
    always_comb begin
        accept = i_Start && ((state == ST_IDLE) || (state == ST_RUN));
        gen_en = (state == ST_LOAD);
    end

    threshold_entry_gen #(
        .CNT_WIDTH   (CNT_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .RATIO_WIDTH (RATIO_WIDTH)
    ) u_entry_gen (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (accept),
        .en         (gen_en),
        .ratio      (r_Ratio),
        .next_entry (next_entry)
    );

    // Sequencer: IDLE/RUN accept start, DRAIN waits out the compare pipe,
    // LOAD writes one entry per cycle with o_BRAM_Addr as the address counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            r_Ratio     <= '0;
            drain_cnt   <= '0;
            o_StartAck  <= 1'b0;
            o_Loaded    <= 1'b0;
            o_InReady   <= 1'b0;
            o_BRAM_Addr <= '0;
            o_BRAM_Din  <= '0;
            o_BRAM_En   <= 1'b0;
            o_BRAM_WrEn <= 1'b0;
        end else begin
            o_StartAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_StartAck  <= 1'b1;
                        r_Ratio     <= i_Ratio;
                        state       <= ST_LOAD;
                        o_BRAM_Addr <= '0;
                        o_BRAM_Din  <= next_entry;
                        o_BRAM_En   <= 1'b1;
                        o_BRAM_WrEn <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        o_StartAck  <= 1'b1;
                        r_Ratio     <= i_Ratio;
                        state       <= ST_DRAIN;
                        drain_cnt   <= DRAIN_W'(PIPE_DEPTH - 1);
                        o_Loaded    <= 1'b0;
                        o_InReady   <= 1'b0;
                        o_BRAM_En   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= ST_LOAD;
                        o_BRAM_Addr <= '0;
                        o_BRAM_Din  <= next_entry;
                        o_BRAM_En   <= 1'b1;
                        o_BRAM_WrEn <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (o_BRAM_Addr == LAST_ADDR) begin
                        state       <= ST_RUN;
                        o_BRAM_Addr <= '0;
                        o_BRAM_Din  <= '0;
                        o_BRAM_En   <= 1'b1;
                        o_BRAM_WrEn <= 1'b0;
                        o_Loaded    <= 1'b1;
                        o_InReady   <= 1'b1;
                    end else begin
                        o_BRAM_Addr <= o_BRAM_Addr + 1'b1;
                        o_BRAM_Din  <= next_entry;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
